// File: rtl/store_merge.sv
// store_merge: turns sw/sh/sb store requests into word-wide data-memory writes.
// Default build: sb/sh perform a read-modify-write (IDLE -> RD -> MERGE -> WR),
// because the data memory has no byte enables. sw goes IDLE -> WR directly.
// Optional feature macro: STORE_BYTEEN_EN. When defined, the memory honours
// MemByteEn, so sb/sh skip RD/MERGE and write the source lane replicated.
// Misaligned sw/sh or an illegal op produce a one-cycle StoreErr and no write.
module store_merge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StoreReq,
  input  logic [2:0]        StoreOp,
  input  logic [ADDR_W-1:0] StoreAddr,
  input  logic [31:0]       StoreData,
  output logic              StoreReady,
  output logic              StoreDone,
  output logic              StoreErr,
  output logic              MemRdEn,
  input  logic [31:0]       MemRData,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [3:0]        MemByteEn
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [2:0] OP_SW = 3'b000;
  localparam logic [2:0] OP_SB = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;

  state_t state, state_next;

  // Latched request: word address, lane mask, lane-replicated data, merge result.
  logic [ADDR_W-3:0] word_q;
  logic [3:0]        lane_q;
  logic [31:0]       data_q;
  logic [31:0]       merge_q;

  // Decode of the incoming request, valid whenever StoreReq is presented.
  logic        accept;
  logic        bad_req;
  logic        is_sw;
  logic [3:0]  lane_d;
  logic [31:0] repl_d;
  logic [31:0] lane_bits;
  logic        mem_phase;

  assign accept = StoreReq & StoreReady;

  // Decode op/address into lane mask, replicated data and the error condition.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    bad_req = 1'b0;
    is_sw   = 1'b0;
    lane_d  = 4'b0000;
    repl_d  = 32'h0;
    case (StoreOp)
      OP_SW: begin
        is_sw   = 1'b1;
        lane_d  = 4'b1111;
        repl_d  = StoreData;
        bad_req = (StoreAddr[1:0] != 2'b00);
      end
      OP_SB: begin
        lane_d  = 4'b0001 << StoreAddr[1:0];
        repl_d  = {4{StoreData[7:0]}};
      end
      OP_SH: begin
        lane_d  = StoreAddr[1] ? 4'b1100 : 4'b0011;
        repl_d  = {2{StoreData[15:0]}};
        bad_req = StoreAddr[0];
      end
      default: begin
        bad_req = 1'b1;
      end
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and Moore outputs for the store sequence.
  always_comb begin
    state_next = state;
    StoreReady = 1'b0;
    StoreDone  = 1'b0;
    StoreErr   = 1'b0;
    MemRdEn    = 1'b0;
    MemWrEn    = 1'b0;
    mem_phase  = 1'b0;
    case (state)
      IDLE: begin
        StoreReady = 1'b1;
        if (accept) begin
          if (bad_req)    state_next = ERR;
          else if (is_sw) state_next = WR;
          else begin
`ifdef STORE_BYTEEN_EN
            state_next = WR;
`else
            state_next = RD;
`endif
          end
        end
      end
      RD: begin
        MemRdEn    = 1'b1;
        mem_phase  = 1'b1;
        state_next = MERGE;
      end
      MERGE: begin
        mem_phase  = 1'b1;
        state_next = WR;
      end
      WR: begin
        MemWrEn    = 1'b1;
        StoreDone  = 1'b1;
        mem_phase  = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        StoreErr   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Expand the 4-bit lane mask to a 32-bit bit mask for the merge.
  assign lane_bits = {{8{lane_q[3]}}, {8{lane_q[2]}}, {8{lane_q[1]}}, {8{lane_q[0]}}};

  // Latch the request on accept; in MERGE splice the new lanes into the read word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      lane_q  <= 4'b0000;
      data_q  <= 32'h0;
      merge_q <= 32'h0;
    end else if (accept) begin
      word_q  <= StoreAddr[ADDR_W-1:2];
      lane_q  <= lane_d;
      data_q  <= repl_d;
      merge_q <= repl_d;
    end else if (state == MERGE) begin
      merge_q <= (MemRData & ~lane_bits) | (data_q & lane_bits);
    end
  end

  // Memory-side address/data/mask only carry the latched store while it is in flight.
  assign MemAddr   = mem_phase ? {word_q, 2'b00} : '0;
  assign MemByteEn = mem_phase ? lane_q : 4'b0000;
  assign MemWData  = MemWrEn ? merge_q : 32'h0;

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge: directed cases plus randomized stores,
// checked by a scoreboard against a byte-addressed reference memory.
// Honours STORE_BYTEEN_EN the same way the design does.
module tb_store_merge;

  localparam int ADDR_W = 32;
`ifdef STORE_BYTEEN_EN
  localparam bit BYTEEN = 1'b1;
`else
  localparam bit BYTEEN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              StoreReq;
  logic [2:0]        StoreOp;
  logic [ADDR_W-1:0] StoreAddr;
  logic [31:0]       StoreData;
  logic              StoreReady;
  logic              StoreDone;
  logic              StoreErr;
  logic              MemRdEn;
  logic [31:0]       MemRData;
  logic              MemWrEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic [3:0]        MemByteEn;

  store_merge #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .StoreReq   (StoreReq),
    .StoreOp    (StoreOp),
    .StoreAddr  (StoreAddr),
    .StoreData  (StoreData),
    .StoreReady (StoreReady),
    .StoreDone  (StoreDone),
    .StoreErr   (StoreErr),
    .MemRdEn    (MemRdEn),
    .MemRData   (MemRData),
    .MemWrEn    (MemWrEn),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemByteEn  (MemByteEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rmw;
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  ref_mem [64];
  logic [31:0] dm [16];
  logic [31:0] rdata_q = 32'h0;
  logic        do_preload = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: registered read, word write (or lane write with byte enables).
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 16; i++) dm[i] <= 32'h1122_3344;
    end else begin
      if (MemRdEn) rdata_q <= dm[MemAddr[5:2]];
      if (MemWrEn) begin
        if (BYTEEN) begin
          for (int k = 0; k < 4; k++)
            if (MemByteEn[k]) dm[MemAddr[5:2]][8*k +: 8] <= MemWData[8*k +: 8];
        end else begin
          dm[MemAddr[5:2]] <= MemWData;
        end
      end
    end
  end
  assign MemRData = rdata_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: apply the store to a byte array and predict the write.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input int unsigned acc);
    exp_t e;
    int   n;
    int   w;
    case (op)
      3'd0:    n = 4;
      3'd1:    n = 1;
      3'd2:    n = 2;
      default: n = 0;
    endcase
    e.err   = (n == 0) || (int'(addr[1:0]) % n != 0);
    e.rmw   = !e.err && (n != 4) && !BYTEEN;
    e.cyc   = acc + (e.rmw ? 2 : 0);
    e.addr  = addr & ~32'h3;
    e.be    = 4'b0000;
    e.wdata = 32'h0;
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        int b;
        b = int'(addr[5:0]) + i;
        ref_mem[b] = data[8*i +: 8];
        e.be[b % 4] = 1'b1;
      end
      w = int'(addr[5:0]) & ~3;
      if (BYTEEN) begin
        for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = data[8*(k % n) +: 8];
      end else begin
        e.wdata = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      end
    end
    sb_q.push_back(e);
  endfunction

  // Monitor: compare every memory strobe / error pulse against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (MemRdEn || MemWrEn)
        check("rd_wr_exclusive", 32'(MemRdEn & MemWrEn), 32'h0);
      if (MemRdEn) begin
        check("rd_for_rmw", 32'(sb_q.size() != 0 && sb_q[0].rmw), 32'h1);
        if (sb_q.size() != 0) check("rd_addr", MemAddr, sb_q[0].addr);
      end
      if (MemWrEn || StoreErr) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: wr=%0b err=%0b with nothing pending (cycle %0d)",
                   MemWrEn, StoreErr, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("err_pulse", 32'(StoreErr), 32'(e.err));
          check("wr_strobe", 32'(MemWrEn), 32'(!e.err));
          check("done_pulse", 32'(StoreDone), 32'(!e.err));
          if (!e.err) begin
            check("wr_addr", MemAddr, e.addr);
            check("wr_data", MemWData, e.wdata);
            check("wr_byteen", 32'(MemByteEn), 32'(e.be));
          end
        end
      end
    end
  end

  // Present a request from a falling edge and hold it until it is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    StoreReq  = 1'b1;
    StoreOp   = op;
    StoreAddr = addr;
    StoreData = data;
    while (!StoreReady && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!StoreReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: StoreReady stayed 0 for %0d cycles", waited);
    end else begin
      model(op, addr, data, cyc + 1);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    StoreReq = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d stores still pending", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic preload();
    @(negedge clk);
    do_preload = 1'b1;
    for (int i = 0; i < 64; i += 4) begin
      ref_mem[i]   = 8'h44;
      ref_mem[i+1] = 8'h33;
      ref_mem[i+2] = 8'h22;
      ref_mem[i+3] = 8'h11;
    end
    @(negedge clk);
    do_preload = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(StoreReady), 32'h1);
    check({tag, "_done"},  32'(StoreDone),  32'h0);
    check({tag, "_err"},   32'(StoreErr),   32'h0);
    check({tag, "_rden"},  32'(MemRdEn),    32'h0);
    check({tag, "_wren"},  32'(MemWrEn),    32'h0);
    check({tag, "_addr"},  MemAddr,         32'h0);
    check({tag, "_wdata"}, MemWData,        32'h0);
    check({tag, "_byteen"}, 32'(MemByteEn), 32'h0);
  endtask

  initial begin
    logic [7:0] saved [64];
    StoreReq  = 1'b0;
    StoreOp   = 3'b000;
    StoreAddr = '0;
    StoreData = 32'h0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    preload();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // Reset asserted while a read-modify-write is in flight: no write may follow.
    if (!BYTEEN) begin
      saved = ref_mem;
      issue(3'b001, 32'h0000_0013, 32'h0000_00AB);
      @(negedge clk);
      check("abort_in_rd", 32'(MemRdEn), 32'h1);
      #1 reset = 1'b0;
      StoreReq = 1'b0;
      sb_q.delete();
      ref_mem = saved;
      repeat (3) begin
        @(negedge clk);
        check("abort_no_wr", 32'(MemWrEn), 32'h0);
      end
      reset = 1'b1;
      @(negedge clk);
      check_idle("post_abort");
      check("abort_mem_intact", dm[4], 32'h1122_3344);
    end

    // Aligned sw.
    issue(3'b000, 32'h0000_0010, 32'hDEAD_BEEF);
    idle(1);
    drain();
    check("sw_mem", dm[4], 32'hDEAD_BEEF);

    // sb to lane 3 and sh to the upper half over a known word.
    preload();
    issue(3'b001, 32'h0000_0013, 32'h0000_00AB);
    idle(1);
    drain();
    check("sb_mem", dm[4], 32'hAB22_3344);
    issue(3'b010, 32'h0000_0006, 32'h0000_CAFE);
    idle(1);
    drain();
    check("sh_mem", dm[1], 32'hCAFE_3344);

    // Errors, with a request held while the error is reported.
    issue(3'b010, 32'h0000_0005, 32'h0000_1234);
    @(negedge clk);
    StoreOp   = 3'b000;
    StoreAddr = 32'h0000_0020;
    StoreData = 32'h0123_4567;
    check("err_busy_ready", 32'(StoreReady), 32'h0);
    issue(3'b000, 32'h0000_0020, 32'h0123_4567);
    issue(3'b011, 32'h0000_0040, 32'hFFFF_FFFF);
    idle(1);
    drain();
    check("after_err_mem", dm[8], 32'h0123_4567);

    if (BYTEEN) begin
      preload();
      issue(3'b001, 32'h0000_0001, 32'h0000_005A);
      idle(1);
      drain();
      check("byteen_sb_mem", dm[0], 32'h1122_5A44);
    end

    // Randomized back-to-back stores, including illegal and misaligned ones.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = (($urandom_range(0, 3) == 0) ? 32'hA000_0000 : 32'h0) | 32'($urandom_range(0, 63));
      d  = $urandom;
      issue(op, a, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    for (int w = 0; w < 16; w++)
      check("final_mem", dm[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
